can_bit_stuffer: RTL

Serial bit-level back end of the CAN transmit path. Sits between the frame transmitter and the physical `tx_bus`/`rx_bus` pins. It accepts one frame bit at a time over a valid/ready handshake, times each bit to `BIT_CLKS` clocks, and inserts a complementary stuff bit after five identical stuffed bits. It also monitors `rx_bus` at the sample point for arbitration loss, bit errors and ACK.

---
 rtl/can_bit_stuffer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/can_bit_stuffer.sv
// can_bit_stuffer: CAN bit timing, stuff-bit insertion and bus readback monitor.
// Define CAN_BIT_MONITOR_EN to enable rx_bus checking (arb_lost/bit_error/ack_seen).
module can_bit_stuffer #(
  parameter int BIT_CLKS  = 16,
  parameter int SAMPLE_PT = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_stuff,
  input  logic in_arb,
  input  logic in_ack,
  input  logic in_last,
  output logic in_ready,
  input  logic rx_bus,
  output logic tx_bus,
  output logic bit_tick,
  output logic stuff_inserted,
  output logic arb_lost,
  output logic bit_error,
  output logic ack_seen,
  output logic underrun,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STUFF
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(BIT_CLKS - 1);
  localparam logic [7:0] CNT_SMP = 8'(SAMPLE_PT);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [2:0] run, run_d;
  logic [2:0] run_base;
  logic       last_bit, last_bit_d;
  logic       cur_last, cur_last_d;
  logic       cur_arb, cur_arb_d;
  logic       cur_ack, cur_ack_d;
  logic       tx_d, tick_d, stuff_d;
  logic       arb_d, berr_d, ack_d, unr_d;
  logic       period_end, stuff_pend, load;

  assign period_end = (state != IDLE) && (cnt == CNT_MAX);
  assign stuff_pend = (state == DATA) && (run == 3'd5);
  assign in_ready   = (state == IDLE) ||
                      (period_end && !stuff_pend && !cur_last);
  assign run_base   = (state == IDLE) ? 3'd0 : run;

  always_comb begin
    state_d    = state;
    cnt_d      = (state == IDLE) ? 8'd0 : cnt + 8'd1;
    run_d      = run;
    last_bit_d = last_bit;
    cur_last_d = cur_last;
    cur_arb_d  = cur_arb;
    cur_ack_d  = cur_ack;
    tx_d       = tx_bus;
    tick_d     = 1'b0;
    stuff_d    = 1'b0;
    arb_d      = 1'b0;
    berr_d     = bit_error;
    ack_d      = ack_seen;
    unr_d      = 1'b0;
    load       = 1'b0;

    unique case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (in_valid) begin
          load   = 1'b1;
          berr_d = 1'b0;
          ack_d  = 1'b0;
        end
      end
      DATA, STUFF: begin
        if (period_end) begin
          cnt_d = 8'd0;
          if (stuff_pend) begin
            state_d    = STUFF;
            tx_d       = ~last_bit;
            tick_d     = 1'b1;
            stuff_d    = 1'b1;
            last_bit_d = ~last_bit;
            run_d      = 3'd1;
            cur_ack_d  = 1'b0;
          end else if (cur_last) begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end else if (in_valid) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            unr_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        cnt_d   = 8'd0;
      end
    endcase

    if (load) begin
      state_d    = DATA;
      cnt_d      = 8'd0;
      tx_d       = in_bit;
      tick_d     = 1'b1;
      cur_last_d = in_last;
      cur_arb_d  = in_arb;
      cur_ack_d  = in_ack;
      if (in_stuff) begin
        run_d      = (run_base != 3'd0 && in_bit == last_bit) ?
                     run_base + 3'd1 : 3'd1;
        last_bit_d = in_bit;
      end else begin
        run_d = 3'd0;
      end
    end

`ifdef CAN_BIT_MONITOR_EN
    // Arbitration loss stops the frame at once and outranks stuff/last.
    if (state != IDLE && cnt == CNT_SMP) begin
      if (cur_arb && tx_bus && !rx_bus) begin
        arb_d   = 1'b1;
        state_d = IDLE;
        tx_d    = 1'b1;
        cnt_d   = 8'd0;
      end else begin
        if (cur_ack && !rx_bus) ack_d = 1'b1;
        if (!cur_ack && tx_bus != rx_bus) berr_d = 1'b1;
      end
    end
`endif
  end

`ifndef CAN_BIT_MONITOR_EN
  logic unused_mon;
  assign unused_mon = ^{rx_bus, cur_arb, cur_ack, CNT_SMP};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      run            <= 3'd0;
      last_bit       <= 1'b1;
      cur_last       <= 1'b0;
      cur_arb        <= 1'b0;
      cur_ack        <= 1'b0;
      tx_bus         <= 1'b1;
      bit_tick       <= 1'b0;
      stuff_inserted <= 1'b0;
      arb_lost       <= 1'b0;
      bit_error      <= 1'b0;
      ack_seen       <= 1'b0;
      underrun       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      run            <= run_d;
      last_bit       <= last_bit_d;
      cur_last       <= cur_last_d;
      cur_arb        <= cur_arb_d;
      cur_ack        <= cur_ack_d;
      tx_bus         <= tx_d;
      bit_tick       <= tick_d;
      stuff_inserted <= stuff_d;
      arb_lost       <= arb_d;
      bit_error      <= berr_d;
      ack_seen       <= ack_d;
      underrun       <= unr_d;
      busy           <= (state_d != IDLE);
    end
  end

endmodule
